bram_window_reader: RTL and testbench

- Read-side sequencer for the audio sample BRAM.
- After the distortion stage has written a full frame of 8-bit samples, it reads that frame back one sample per window.
- It keeps a 5-tap sliding history and presents each window to the moving-average filter through a valid/ready handshake.
- It sits between the BRAM read port and the filter input, replacing the ad-hoc multi-read addressing with one sequential reader.

---
 rtl/audio_pkg.sv | 19 +
 rtl/tap_shift_reg.sv | 24 ++
 rtl/bram_window_reader.sv | 102 ++++++++++
 tb/tb_bram_window_reader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and types for the audio sample path (distortion, reader, filter).
package audio_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned TAPS   = 5;

    typedef logic [DATA_W-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        PRESENT,
        DONE
    } reader_state_t;

endpackage

// File: rtl/tap_shift_reg.sv
// Sliding sample history: tap 0 holds the newest sample, the oldest tap falls off on each shift.
module tap_shift_reg #(
    parameter int unsigned TAPS   = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   shift_en,
    input  logic [DATA_W-1:0]      din,
    output logic [TAPS*DATA_W-1:0] taps
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (clr) begin
            taps <= '0;
        end else if (shift_en) begin
            taps <= {taps[(TAPS-1)*DATA_W-1:0], din};
        end
    end

endmodule

// File: rtl/bram_window_reader.sv
// Sequential frame reader: fetches one BRAM sample per window and presents a TAPS-deep
// sliding history to the filter over a valid/ready handshake.
module bram_window_reader #(
    parameter int unsigned DEPTH  = audio_pkg::DEPTH,
    parameter int unsigned ADDR_W = audio_pkg::ADDR_W,
    parameter int unsigned DATA_W = audio_pkg::DATA_W,
    parameter int unsigned TAPS   = audio_pkg::TAPS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   bram_rd_en,
    output logic [ADDR_W-1:0]      bram_addr,
    input  logic [DATA_W-1:0]      bram_rd_data,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic [TAPS*DATA_W-1:0] win_data,
    output logic [ADDR_W-1:0]      win_index
);

    import audio_pkg::*;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    reader_state_t     state;
    logic [ADDR_W-1:0] count;
    logic              hist_clr;
    logic              hist_shift;

    // History clears on the accepting edge so window 0 sees zero-padded older taps.
    assign hist_clr   = (state == IDLE) && start;
    assign hist_shift = (state == CAPTURE);

    tap_shift_reg #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W)
    ) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (hist_clr),
        .shift_en (hist_shift),
        .din      (bram_rd_data),
        .taps     (win_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bram_rd_en <= 1'b0;
            bram_addr  <= '0;
            win_valid  <= 1'b0;
            win_index  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count      <= '0;
                        busy       <= 1'b1;
                        bram_rd_en <= 1'b1;
                        bram_addr  <= '0;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    bram_rd_en <= 1'b0;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    win_index <= count;
                    win_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (count == LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            count      <= count + 1'b1;
                            bram_addr  <= count + 1'b1;
                            bram_rd_en <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_window_reader.sv
// Directed bench for bram_window_reader with a registered BRAM model and a window monitor.
module tb_bram_window_reader;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int NT = 5;
    localparam int DP = 1024;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            win_ready = 1'b0;
    logic            busy;
    logic            done;
    logic            bram_rd_en;
    logic [AW-1:0]   bram_addr;
    logic [DW-1:0]   bram_rd_data = '0;
    logic            win_valid;
    logic [NT*DW-1:0] win_data;
    logic [AW-1:0]   win_index;

    logic [DW-1:0]    mem [DP];
    logic [AW-1:0]    q_idx [$];
    logic [NT*DW-1:0] q_dat [$];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int done_cnt = 0;

    bram_window_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .bram_rd_en   (bram_rd_en),
        .bram_addr    (bram_addr),
        .bram_rd_data (bram_rd_data),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_data     (win_data),
        .win_index    (win_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_rd_en) bram_rd_data <= mem[bram_addr];
    end

    // Inputs change 1 time unit after posedge, so negedge sees what the next edge will sample.
    always @(negedge clk) begin
        if (bram_rd_en === 1'b1) rd_cnt++;
        if (done === 1'b1) done_cnt++;
        if (win_valid === 1'b1 && win_ready === 1'b1) begin
            q_idx.push_back(win_index);
            q_dat.push_back(win_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        rd_cnt = 0;
        done_cnt = 0;
        q_idx.delete();
        q_dat.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < DP; i++) mem[i] = 8'(i);
    endtask

    task automatic run_until_done(input int budget, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_window(input int idx, input int budget, output int waited);
        waited = 0;
        while (!(win_valid === 1'b1 && win_index === AW'(idx)) && waited < budget) begin
            tick();
            waited++;
        end
    endtask

    function automatic logic [NT*DW-1:0] ref_win(input int i);
        logic [NT*DW-1:0] w;
        w = '0;
        for (int t = 0; t < NT; t++) begin
            if (i - t >= 0) w[t*DW +: DW] = mem[i - t];
        end
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, bram_rd_en, bram_addr, win_valid, win_data, win_index} !== '0)
            begin errors++; $display("FAIL reset_outputs got busy=%b done=%b rd_en=%b addr=%0d valid=%b data=%h idx=%0d want all 0",
                busy, done, bram_rd_en, bram_addr, win_valid, win_data, win_index); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ramp();
        int cyc;
        int first_v;
        load_ramp();
        clear_mon();
        win_ready = 1'b1;
        first_v = -1;
        do_start();
        cyc = 1;
        checks++;
        if ({busy, bram_rd_en, bram_addr} !== {2'b11, 10'd0})
            begin errors++; $display("FAIL ramp_start got busy=%b rd_en=%b addr=%0d want 1 1 0", busy, bram_rd_en, bram_addr); end
        while (done !== 1'b1 && cyc < 4000) begin
            if (win_valid === 1'b1 && first_v < 0) first_v = cyc;
            tick();
            cyc++;
        end
        checks++;
        if (first_v !== 3) begin errors++; $display("FAIL ramp_first_valid got cycle %0d want 3", first_v); end
        checks++;
        if (cyc !== 3073 || done !== 1'b1) begin errors++; $display("FAIL ramp_frame_cycles got %0d done=%b want 3073 done=1", cyc, done); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_at_done got %b want 0", busy); end
        checks++;
        if (rd_cnt !== 1024) begin errors++; $display("FAIL ramp_read_count got %0d want 1024", rd_cnt); end
        checks++;
        if (q_idx.size() !== 1024) begin
            errors++; $display("FAIL ramp_window_count got %0d want 1024", q_idx.size());
        end else begin
            checks++;
            if (q_dat[0] !== 40'h0 || q_idx[0] !== 10'd0)
                begin errors++; $display("FAIL ramp_win0 got %h idx %0d want 0000000000 idx 0", q_dat[0], q_idx[0]); end
            checks++;
            if (q_dat[2] !== 40'h00_00_00_01_02 || q_idx[2] !== 10'd2)
                begin errors++; $display("FAIL ramp_win2 got %h idx %0d want 0000000102 idx 2", q_dat[2], q_idx[2]); end
            checks++;
            if (q_dat[10] !== 40'h06_07_08_09_0A || q_idx[10] !== 10'd10)
                begin errors++; $display("FAIL ramp_win10 got %h idx %0d want 060708090a idx 10", q_dat[10], q_idx[10]); end
            checks++;
            if (q_dat[1023] !== 40'hFB_FC_FD_FE_FF || q_idx[1023] !== 10'd1023)
                begin errors++; $display("FAIL ramp_win1023 got %h idx %0d want fbfcfdfeff idx 1023", q_dat[1023], q_idx[1023]); end
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin errors++; $display("FAIL ramp_done_pulse got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_backpressure();
        int waited;
        int r0;
        int cyc;
        load_ramp();
        clear_mon();
        win_ready = 1'b1;
        do_start();
        wait_window(4, 100, waited);
        checks++;
        if (waited >= 100) begin errors++; $display("FAIL bp_reach_idx4 got timeout want window 4"); end
        win_ready = 1'b0;
        r0 = rd_cnt;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if ({win_valid, win_index, win_data} !== {1'b1, 10'd4, 40'h00_01_02_03_04})
                begin errors++; $display("FAIL bp_stall_%0d got valid=%b idx=%0d data=%h want 1 4 0001020304", k, win_valid, win_index, win_data); end
            tick();
        end
        checks++;
        if (rd_cnt !== r0) begin errors++; $display("FAIL bp_no_extra_read got %0d reads want %0d", rd_cnt, r0); end
        win_ready = 1'b1;
        tick();
        checks++;
        if (win_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b want 0", win_valid); end
        wait_window(5, 10, waited);
        checks++;
        if (waited >= 10 || win_data !== 40'h01_02_03_04_05)
            begin errors++; $display("FAIL bp_resume got idx=%0d data=%h want 5 0102030405", win_index, win_data); end
        run_until_done(4000, cyc);
        checks++;
        if (done !== 1'b1 || q_idx.size() !== 1024 || rd_cnt !== 1024)
            begin errors++; $display("FAIL bp_frame got done=%b windows=%0d reads=%0d want 1 1024 1024", done, q_idx.size(), rd_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        int waited;
        int d0;
        int cyc;
        load_ramp();
        clear_mon();
        win_ready = 1'b1;
        do_start();
        wait_window(500, 2000, waited);
        checks++;
        if (waited >= 2000) begin errors++; $display("FAIL rst_reach_idx500 got timeout want window 500"); end
        win_ready = 1'b0;
        tick();
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bram_rd_en, bram_addr, win_valid, win_data, win_index} !== '0)
            begin errors++; $display("FAIL rst_mid_outputs got busy=%b done=%b rd_en=%b addr=%0d valid=%b data=%h idx=%0d want all 0",
                busy, done, bram_rd_en, bram_addr, win_valid, win_data, win_index); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_done got done pulses %0d busy=%b want %0d 0", done_cnt, busy, d0); end
        clear_mon();
        win_ready = 1'b1;
        do_start();
        wait_window(0, 10, waited);
        checks++;
        if (waited >= 10 || win_data !== 40'h0 || win_valid !== 1'b1)
            begin errors++; $display("FAIL rst_restart got valid=%b idx=%0d data=%h want 1 0 0000000000", win_valid, win_index, win_data); end
        run_until_done(4000, cyc);
        tick();
        checks++;
        if (done_cnt !== 1 || q_idx.size() !== 1024)
            begin errors++; $display("FAIL rst_restart_frame got done pulses %0d windows %0d want 1 1024", done_cnt, q_idx.size()); end
    endtask

    task automatic test_start_busy();
        int waited;
        int cyc;
        int bad;
        load_ramp();
        clear_mon();
        win_ready = 1'b1;
        do_start();
        wait_window(100, 400, waited);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_done(4000, cyc);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL sb_done got timeout want done"); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, bram_rd_en, done} !== 3'b000)
            begin errors++; $display("FAIL sb_start_at_done got busy=%b rd_en=%b done=%b want 0 0 0", busy, bram_rd_en, done); end
        bad = 0;
        for (int k = 0; k < q_idx.size(); k++) if (q_idx[k] !== AW'(k)) bad++;
        checks++;
        if (done_cnt !== 1 || q_idx.size() !== 1024 || bad != 0)
            begin errors++; $display("FAIL sb_single_frame got done pulses %0d windows %0d out-of-order %0d want 1 1024 0", done_cnt, q_idx.size(), bad); end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL sb_idle got busy=%b want 0", busy); end
        do_start();
        checks++;
        if ({busy, bram_rd_en, bram_addr} !== {2'b11, 10'd0})
            begin errors++; $display("FAIL sb_restart got busy=%b rd_en=%b addr=%0d want 1 1 0", busy, bram_rd_en, bram_addr); end
        run_until_done(4000, cyc);
        tick();
        checks++;
        if (done_cnt !== 2) begin errors++; $display("FAIL sb_second_frame got done pulses %0d want 2", done_cnt); end
    endtask

    task automatic test_random();
        int cyc;
        for (int i = 0; i < DP; i++) mem[i] = 8'($urandom);
        clear_mon();
        win_ready = 1'b0;
        do_start();
        cyc = 0;
        while (done !== 1'b1 && cyc < 30000) begin
            win_ready = ($urandom_range(0, 99) < 30);
            tick();
            cyc++;
        end
        win_ready = 1'b1;
        checks++;
        if (done !== 1'b1 || q_idx.size() !== 1024)
            begin errors++; $display("FAIL rnd_frame got done=%b windows=%0d want 1 1024", done, q_idx.size()); end
        else begin
            for (int k = 0; k < DP; k++) begin
                checks++;
                if (q_idx[k] !== AW'(k) || q_dat[k] !== ref_win(k))
                    begin errors++; $display("FAIL rnd_win%0d got idx %0d data %h want idx %0d data %h", k, q_idx[k], q_dat[k], k, ref_win(k)); end
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
